// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encodings and defaults for the input debouncer
package debounce_pkg;
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b11,
    WAIT_LO = 2'b10
  } state_e;
  localparam int DEF_STABLE_CYCLES = 16;
endpackage

// File: rtl/button_debounce_sync_sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs, q resets to 0
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/button_debounce_sync.sv
// button_debounce_sync: synchronizes a bouncy input and qualifies level changes over a stable window
module button_debounce_sync
  import debounce_pkg::*;
#(
  parameter  int STABLE_CYCLES = DEF_STABLE_CYCLES,
  localparam int CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d, rise_q, rise_d, fall_q, fall_d, busy_q, busy_d;
  logic             s2;
  sync2 u_sync (.clk(clk), .rst(rst), .d(din), .q(s2));
  // any sample of the old level during a wait drops straight back to idle with no credit kept
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        state_d = s2 ? WAIT_HI : IDLE_LO;
        cnt_d   = s2 ? CNT_W'(1) : '0;
      end
      WAIT_HI: begin
        if (!s2) state_d = IDLE_LO;
        else if (cnt_q == LAST) begin
          state_d = IDLE_HI;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      IDLE_HI: begin
        state_d = s2 ? IDLE_HI : WAIT_LO;
        cnt_d   = s2 ? '0 : CNT_W'(1);
      end
      WAIT_LO: begin
        if (s2) state_d = IDLE_HI;
        else if (cnt_q == LAST) begin
          state_d = IDLE_LO;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
    endcase
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end
  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_button_debounce_sync.sv
// tb_button_debounce_sync: directed and random checks against a window-based reference model
module tb_button_debounce_sync;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst, din, dout, rise, fall, busy;
  int tests = 0, fails = 0;
  logic m_dout = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;
  logic samp[$];
  logic seen[$];

  button_debounce_sync #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;

  // dout flips once the last S levels seen after synchronization all differ from it
  task automatic model();
    logic s, flip;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!rst) begin
      samp.delete();
      seen.delete();
      m_dout = 1'b0;
      m_busy = 1'b0;
      return;
    end
    s = (samp.size() >= 2) ? samp[samp.size()-2] : 1'b0;
    samp.push_back(din);
    if (samp.size() > 4) void'(samp.pop_front());
    seen.push_back(s);
    if (seen.size() > S) void'(seen.pop_front());
    flip = (seen.size() == S);
    for (int i = 0; i < S; i++) if (flip && seen[i] == m_dout) flip = 1'b0;
    if (flip) begin
      m_dout = ~m_dout;
      m_rise = m_dout;
      m_fall = ~m_dout;
      seen.delete();
    end
    m_busy = !flip && (s != m_dout);
  endtask

  task automatic chk(input string tag);
    tests += 5;
    assert (dout === m_dout) else begin fails++; $error("FAIL %s dout got %b exp %b", tag, dout, m_dout); end
    assert (rise === m_rise) else begin fails++; $error("FAIL %s rise got %b exp %b", tag, rise, m_rise); end
    assert (fall === m_fall) else begin fails++; $error("FAIL %s fall got %b exp %b", tag, fall, m_fall); end
    assert (busy === m_busy) else begin fails++; $error("FAIL %s busy got %b exp %b", tag, busy, m_busy); end
    assert (!(rise && fall)) else begin fails++; $error("FAIL %s both pulses got %b%b exp 00", tag, rise, fall); end
  endtask

  task automatic cyc(input logic d, input logic r, input string tag);
    din = d;
    rst = r;
    @(posedge clk);
    model();
    @(negedge clk);
    chk(tag);
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    tests++;
    assert (got == exp) else begin fails++; $error("FAIL %s got %0d exp %0d", tag, got, exp); end
  endtask

  initial begin
    int at, n;
    logic [7:0] bmask;
    logic lvl, d0;
    din = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, "reset");
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, "settle");

    at = -1; bmask = '0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, "clean_rise");
      if (rise && at < 0) at = k;
      bmask[k] = busy;
    end
    expect_int("rise_edge", at, 5);
    expect_int("rise_busy_mask", int'(bmask), 8'b0001_1100);

    at = -1; n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, "clean_fall");
      if (fall && at < 0) at = k;
      n += int'(fall);
    end
    expect_int("fall_edge", at, 5);
    expect_int("fall_count", n, 1);

    n = 0; bmask = '0;
    foreach (bmask[k]) bmask[k] = 1'b0;
    for (int k = 0; k < 13; k++) begin
      cyc((k < 3 || (k >= 4 && k < 7)) ? 1'b1 : 1'b0, 1'b1, "bounce");
      n += int'(rise) + int'(fall);
      if (busy) bmask[0] = 1'b1;
    end
    expect_int("bounce_edges", n, 0);
    expect_int("bounce_busy_seen", int'(bmask[0]), 1);
    expect_int("bounce_busy_end", int'(busy), 0);
    expect_int("bounce_dout", int'(dout), 0);

    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, "mid_pre");
    cyc(1'b1, 1'b0, "mid_reset");
    expect_int("mid_reset_busy", int'(busy), 0);
    at = -1;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, "mid_post");
      if (rise && at < 0) at = k;
    end
    expect_int("mid_rise_edge", at, 5);

    d0 = dout; lvl = ~dout; n = 0;
    for (int k = 0; k < 200; ) begin
      int run = int'($urandom_range(1, 3));
      for (int j = 0; j < run && k < 200; j++, k++) begin
        cyc(lvl, 1'b1, "random_bounce");
        n += int'(rise) + int'(fall);
      end
      lvl = ~lvl;
    end
    expect_int("random_edges", n, 0);
    expect_int("random_dout", int'(dout), int'(d0));

    lvl = 1'($urandom_range(0, 1)); n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(lvl, 1'b1, "random_hold");
      n += int'(rise) + int'(fall);
    end
    expect_int("hold_edges", n, (lvl != d0) ? 1 : 0);
    expect_int("hold_dout", int'(dout), int'(lvl));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
